// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, sticky overflow/underflow errors and an optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_ok, wr_ok;

  always_comb begin
    rd_ok = rd_en & ~empty_q;
    // a read at full frees the slot the simultaneous write lands in
    wr_ok = wr_en & (~full_q | rd_ok);

    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);

    // a new error on the same edge as clr_err still latches
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_ok);
    udf_d = (udf_q & ~clr_err) | (rd_en & empty_q);

    dout_d = dout_q;
    if (rd_ok) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = FWFT ? (empty_q ? '0 : mem_q[rd_ptr_q]) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard-read instance checked every cycle against a
// queue model, plus a first-word-fall-through instance for the FWFT behaviour.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_data_in, f_data_out;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == 16));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  // drive at negedge, let the posedge act, update the model, check at next negedge
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic rd_ok, wr_ok;
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < 16) || rd_ok);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && mq.size() == 0) m_udf = 1'b1;
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    mq.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic f_check(input string tag, input int n, input logic [7:0] head);
    chk({tag, "_empty"}, 32'(f_empty), 32'(n == 0));
    chk({tag, "_count"}, 32'(f_count), 32'(n));
    chk({tag, "_full"},  32'(f_full),  32'(n == 16));
    chk({tag, "_af"},    32'(f_af),    32'(n >= 14));
    chk({tag, "_ae"},    32'(f_ae),    32'(n <= 2));
    chk({tag, "_ovf"},   32'(f_ovf),   32'(0));
    chk({tag, "_udf"},   32'(f_udf),   32'(0));
    if (n > 0) chk({tag, "_data"}, 32'(f_data_out), 32'(head));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_data_in = 0;
    m_dout = 0; m_ovf = 0; m_udf = 0;
    @(negedge clk);
    do_reset();
    f_check("fwft_reset", 0, 8'h00);

    // fill to full, then one rejected write
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);

    // drain in order, then one rejected read
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read+write at full
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last_read_aa", 32'(data_out), 32'(8'hAA));

    // simultaneous read+write at empty
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("read_55", 32'(data_out), 32'(8'h55));

    // fall-through instance
    f_wr_en = 1'b1; f_data_in = 8'h3C;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_data_in = 8'h4D;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_wr_en = 1'b0;
    f_check("fwft_two", 2, 8'h3C);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_check("fwft_hold", 2, 8'h3C);
    f_rd_en = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_check("fwft_pop1", 1, 8'h4D);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_rd_en = 1'b0;
    f_check("fwft_pop2", 0, 8'h00);
    f_wr_en = 1'b1; f_data_in = 8'h3C;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_wr_en = 1'b0;
    f_check("fwft_3c", 1, 8'h3C);
    f_rd_en = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    f_rd_en = 1'b0;
    f_check("fwft_empty", 0, 8'h00);

    // random traffic with a mid-stream reset
    for (int i = 0; i < 40; i++) begin
      if (i == 25) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
